result_display_stage: RTL and testbench

Downstream stage for the asynchronous processing block. It receives the block's 4-bit result over a bundled-data four-phase req/ack handshake and synchronises the request into the clk domain. Results are buffered in a small FIFO and shown one at a time on the 7-segment output for a fixed dwell time. It frees uo_out from its current constant-zero tie-off.

---
 rtl/display_pkg.sv | 23 ++
 rtl/result_display_stage_fifo.sv | 60 ++++++
 rtl/result_display_stage.sv | 142 ++++++++++++++
 tb/tb_result_display_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encodings and 7-segment table for result_display_stage
package display_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ACKED = 1'b1
   } hs_state_t;

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      FRESH = 2'd1,
      STALE = 2'd2
   } disp_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Segment codes gfedcba, indexed by nibble value (entry 0 is the least significant slot)
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/result_display_stage_fifo.sv
// rtl/result_display_stage_fifo.sv - nibble_fifo, small circular buffer of 4-bit results
module nibble_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [3:0]               din,
   output logic [3:0]               dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == FULL_COUNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are exactly AW bits wide so they wrap at DEPTH on their own
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/result_display_stage.sv
// rtl/result_display_stage.sv - four-phase result receiver, FIFO buffer and timed 7-segment display
module result_display_stage
   import display_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_in,
   input  logic [3:0]               data_in,
   output logic                     ack_out,
   output logic [6:0]               seg_out,
   output logic                     dp_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   hs_state_t              hs_state;
   hs_state_t              hs_next;
   disp_state_t            disp_state;
   disp_state_t            disp_next;
   logic [TW-1:0]          timer_q;
   logic [TW-1:0]          timer_next;
   logic [6:0]             seg_q;
   logic [6:0]             seg_next;
   logic                   push;
   logic                   pop;
   logic [3:0]             fifo_dout;
   logic                   fifo_full;
   logic                   fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
      end
   end

   assign req_s = sync_q[SYNC_STAGES-1];

   nibble_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (data_in),
      .dout  (fifo_dout),
      .count (count_out),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_state <= IDLE;
      end else begin
         hs_state <= hs_next;
      end
   end

   // A full FIFO simply withholds the acknowledge; the sender waits with data held
   always_comb begin
      hs_next = hs_state;
      push    = 1'b0;
      case (hs_state)
         IDLE: begin
            if (req_s && !fifo_full) begin
               hs_next = ACKED;
               push    = 1'b1;
            end
         end
         ACKED: begin
            if (!req_s) begin
               hs_next = IDLE;
            end
         end
         default: hs_next = IDLE;
      endcase
   end

   assign ack_out = (hs_state == ACKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_state <= BLANK;
         timer_q    <= '0;
         seg_q      <= SEG_BLANK;
      end else begin
         disp_state <= disp_next;
         timer_q    <= timer_next;
         seg_q      <= seg_next;
      end
   end

   // Pops look only at the registered occupancy, so a same-edge push is never popped
   always_comb begin
      disp_next  = disp_state;
      timer_next = timer_q;
      seg_next   = seg_q;
      pop        = 1'b0;
      case (disp_state)
         BLANK, STALE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               disp_next  = FRESH;
               timer_next = TIMER_LOAD;
               seg_next   = HEX_SEG[fifo_dout];
            end
         end
         FRESH: begin
            if (timer_q == '0) begin
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  timer_next = TIMER_LOAD;
                  seg_next   = HEX_SEG[fifo_dout];
               end else begin
                  disp_next = STALE;
               end
            end else begin
               timer_next = timer_q - 1'b1;
            end
         end
         default: begin
            disp_next = BLANK;
            seg_next  = SEG_BLANK;
         end
      endcase
   end

   assign seg_out = seg_q;
   assign dp_out  = (disp_state == FRESH);

endmodule

// File: tb/tb_result_display_stage.sv
// tb/tb_result_display_stage.sv - directed self-checking bench for result_display_stage
module tb_result_display_stage;

   localparam int DEPTH = 4;
   localparam int HOLD  = 16;
   localparam int SYNC  = 2;

   typedef struct {
      logic [6:0] seg;
      int         len;
      bit         joined;
   } run_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_in = 1'b0;
   logic [3:0] data_in = 4'h0;
   logic       ack_out;
   logic [6:0] seg_out;
   logic       dp_out;
   logic [2:0] count_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   run_t       runs[$];
   run_t       cur;
   bit         active = 1'b0;
   logic [3:0] expv[$];

   result_display_stage #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_in    (req_in),
      .data_in   (data_in),
      .ack_out   (ack_out),
      .seg_out   (seg_out),
      .dp_out    (dp_out),
      .count_out (count_out)
   );

   always #5 clk = ~clk;

   // Records each stretch of dp_out=1 per displayed value and whether it followed another without a gap
   always @(negedge clk) begin
      if (rst) begin
         active = 1'b0;
      end else if (dp_out) begin
         if (active && seg_out == cur.seg) begin
            cur.len++;
         end else begin
            if (active) runs.push_back(cur);
            cur.seg    = seg_out;
            cur.len    = 1;
            cur.joined = active;
            active     = 1'b1;
         end
      end else if (active) begin
         runs.push_back(cur);
         active = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic handshake(input logic [3:0] d);
      data_in = d;
      req_in  = 1'b1;
      for (int i = 0; i < 40 && !ack_out; i++) tick(1);
      check("hs_ack_rise", ack_out, 1);
      req_in = 1'b0;
      for (int i = 0; i < 40 && ack_out; i++) tick(1);
      check("hs_ack_fall", ack_out, 0);
   endtask

   task automatic wait_stale();
      for (int i = 0; i < 200 && dp_out; i++) tick(1);
      tick(1);
      check("stale_dp", dp_out, 0);
   endtask

   task automatic check_runs();
      check("run_count", runs.size(), expv.size());
      for (int i = 0; i < expv.size() && i < runs.size(); i++) begin
         check("run_seg", runs[i].seg, seg_ref[expv[i]]);
         check("run_len", runs[i].len, HOLD);
         check("run_joined", runs[i].joined, (i > 0) ? 1 : 0);
      end
   endtask

   initial begin
      // Power-on reset
      tick(2);
      check("rst_ack", ack_out, 0);
      check("rst_seg", seg_out, 7'h00);
      check("rst_dp", dp_out, 0);
      check("rst_count", count_out, 0);
      #2 rst = 1'b0;
      tick(1);

      // Single handshake, latency and dwell
      data_in = 4'h5;
      req_in  = 1'b1;
      tick(2);
      check("t2_ack_early", ack_out, 0);
      tick(1);
      check("t2_ack", ack_out, 1);
      check("t2_count", count_out, 1);
      check("t2_seg_pre", seg_out, 7'h00);
      tick(1);
      check("t2_seg", seg_out, 7'h6D);
      check("t2_dp", dp_out, 1);
      check("t2_count_pop", count_out, 0);
      tick(15);
      check("t2_dp_last", dp_out, 1);
      tick(1);
      check("t2_dp_off", dp_out, 0);
      check("t2_seg_stale", seg_out, 7'h6D);
      req_in = 1'b0;
      tick(2);
      check("t2_ack_hold", ack_out, 1);
      tick(1);
      check("t2_ack_drop", ack_out, 0);

      // Asynchronous reset at a random clock phase
      @(posedge clk);
      #($urandom_range(2, 7));
      rst = 1'b1;
      #1;
      check("t1_seg", seg_out, 7'h00);
      check("t1_dp", dp_out, 0);
      check("t1_ack", ack_out, 0);
      check("t1_count", count_out, 0);
      #1 rst = 1'b0;
      tick(3);
      check("t1_seg_after", seg_out, 7'h00);
      check("t1_count_after", count_out, 0);

      // Four back-to-back results
      runs.delete();
      handshake(4'h1);
      handshake(4'h2);
      handshake(4'h3);
      handshake(4'h4);
      wait_stale();
      check("t3_seg_stale", seg_out, 7'h66);
      expv = '{4'h1, 4'h2, 4'h3, 4'h4};
      check_runs();

      // Back-pressure: fill the FIFO then hold one more request off
      runs.delete();
      for (int v = 8; v < 15; v++) handshake(4'(v));
      check("t4_full", count_out, 4);
      data_in = 4'hF;
      req_in  = 1'b1;
      tick(5);
      check("t4_ack_held", ack_out, 0);
      check("t4_count_held", count_out, 4);
      for (int i = 0; i < 30 && count_out == 3'd4; i++) tick(1);
      check("t4_count_pop", count_out, 3);
      check("t4_ack_pop", ack_out, 0);
      tick(1);
      check("t4_ack_rise", ack_out, 1);
      check("t4_count_refill", count_out, 4);
      req_in = 1'b0;
      for (int i = 0; i < 40 && ack_out; i++) tick(1);
      check("t4_ack_fall", ack_out, 0);
      wait_stale();
      check("t4_seg_stale", seg_out, 7'h71);
      expv = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      check_runs();

      // Push coinciding with a timer-expiry pop at count 2
      handshake(4'h0);
      handshake(4'hA);
      handshake(4'hB);
      handshake(4'hD);
      check("t5_count_pre", count_out, 2);
      tick(9);
      data_in = 4'hE;
      req_in  = 1'b1;
      tick(2);
      check("t5_count_before", count_out, 2);
      check("t5_seg_before", seg_out, 7'h77);
      tick(1);
      check("t5_count_same", count_out, 2);
      check("t5_seg_next", seg_out, 7'h7C);
      check("t5_dp", dp_out, 1);
      check("t5_ack", ack_out, 1);
      req_in = 1'b0;
      for (int i = 0; i < 40 && ack_out; i++) tick(1);
      check("t5_ack_fall", ack_out, 0);
      wait_stale();
      check("t5_seg_stale", seg_out, 7'h79);

      // Reset while acknowledged with the request still high
      data_in = 4'h9;
      req_in  = 1'b1;
      tick(3);
      check("t6_ack_pre", ack_out, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_ack_rst", ack_out, 0);
      check("t6_count_rst", count_out, 0);
      check("t6_seg_rst", seg_out, 7'h00);
      #2 rst = 1'b0;
      tick(2);
      check("t6_ack_early", ack_out, 0);
      tick(1);
      check("t6_ack_again", ack_out, 1);
      check("t6_count", count_out, 1);
      tick(1);
      check("t6_seg", seg_out, 7'h6F);
      check("t6_dp", dp_out, 1);
      req_in = 1'b0;
      for (int i = 0; i < 40 && ack_out; i++) tick(1);
      check("t6_ack_fall", ack_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
